// File: rtl/edu_tpu_pkg.sv
// Shared definitions for the edu_tpu Wishbone host.
//   state_t           : host FSM states
//   TPU_BASE_ADDRESS  : address of the TPU slave's single register
//   N_WEIGHT/N_INPUT  : words written per job (weights first, then inputs)
//   N_RESULT          : words read back per job
//   INPUT_MASK        : input words carry only 24 significant bits
package edu_tpu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WR_REQ,
        WR_GAP,
        SETTLE,
        RD_REQ,
        RD_GAP,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] TPU_BASE_ADDRESS = 32'h3000_0000;
    localparam int          N_WEIGHT         = 4;
    localparam int          N_INPUT          = 6;
    localparam int          N_RESULT         = 5;
    localparam logic [31:0] INPUT_MASK       = 32'h00FF_FFFF;

endpackage

// File: rtl/wb_ack_timer.sv
// Saturating wait counter for Wishbone acknowledge timeouts.
//   clk      : clock
//   rst      : synchronous active-high reset
//   clr      : holds the counter at zero (asserted whenever no request is pending)
//   timeout  : high once the counter has reached TIMEOUT; stays high until clr
module wb_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic timeout
);

    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout = (cnt_reg == LIMIT);

endmodule

// File: rtl/edu_tpu_wb_host.sv
// Wishbone classic initiator that runs one edu_tpu job: N_WEIGHT weight
// writes, N_INPUT input writes, a settle wait, then N_RESULT result reads,
// all at a single register address.
//   caravel_wb_clk_i / caravel_wb_rst_i : clock, synchronous active-high reset
//   start_i                              : job start pulse (ignored while busy)
//   src_valid_i / src_data_i / src_ready_o : word stream supplying weights/inputs
//   res_valid_o / res_data_o             : one pulse per result word
//   busy_o / done_o / err_o              : job status (err_o sticky until start)
//   wbm_*                                : Wishbone initiator port
module edu_tpu_wb_host
    import edu_tpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS  = edu_tpu_pkg::TPU_BASE_ADDRESS,
    parameter int          N_WEIGHT      = edu_tpu_pkg::N_WEIGHT,
    parameter int          N_INPUT       = edu_tpu_pkg::N_INPUT,
    parameter int          N_RESULT      = edu_tpu_pkg::N_RESULT,
    parameter int          SETTLE_CYCLES = 64,
    parameter int          TIMEOUT       = 255
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_i,
    input  logic        start_i,
    input  logic        src_valid_i,
    input  logic [31:0] src_data_i,
    output logic        src_ready_o,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int WCW = $clog2(N_WEIGHT + N_INPUT + 1);
    localparam int RCW = $clog2(N_RESULT + 1);
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [WCW-1:0] N_WR        = WCW'(N_WEIGHT + N_INPUT);
    localparam logic [WCW-1:0] N_WT        = WCW'(N_WEIGHT);
    localparam logic [RCW-1:0] N_RD        = RCW'(N_RESULT);
    localparam logic [RCW-1:0] LAST_RD     = RCW'(N_RESULT - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    state_t         state_reg;
    logic [WCW-1:0] wcnt_reg;
    logic [RCW-1:0] rcnt_reg;
    logic [SCW-1:0] settle_reg;
    logic           bus_reg;       // cyc and stb always move together
    logic           we_reg;
    logic [31:0]    dat_reg;
    logic           ready_reg;
    logic           res_valid_reg;
    logic [31:0]    res_data_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           err_reg;

    logic in_req;
    logic ack_timeout;

    assign in_req = (state_reg == WR_REQ) || (state_reg == RD_REQ);

    // Counter is held at zero outside the request states, so it restarts
    // from zero on every new request.
    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk     (caravel_wb_clk_i),
        .rst     (caravel_wb_rst_i),
        .clr     (!in_req),
        .timeout (ack_timeout)
    );

    always_ff @(posedge caravel_wb_clk_i) begin
        if (caravel_wb_rst_i) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            rcnt_reg      <= '0;
            settle_reg    <= '0;
            bus_reg       <= 1'b0;
            we_reg        <= 1'b0;
            dat_reg       <= '0;
            ready_reg     <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        busy_reg  <= 1'b1;
                        err_reg   <= 1'b0;
                        wcnt_reg  <= '0;
                        rcnt_reg  <= '0;
                        ready_reg <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (src_valid_i) begin
                        ready_reg <= 1'b0;
                        // Input words follow the weights and carry 24 bits only.
                        dat_reg   <= (wcnt_reg >= N_WT) ? (src_data_i & INPUT_MASK) : src_data_i;
                        bus_reg   <= 1'b1;
                        we_reg    <= 1'b1;
                        state_reg <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (wbm_ack_i) begin
                        bus_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        wcnt_reg  <= wcnt_reg + 1'b1;
                        state_reg <= WR_GAP;
                    end else if (ack_timeout) begin
                        bus_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= ERR;
                    end
                end
                WR_GAP: begin
                    // One idle cycle lets the slave's registered ack fall.
                    if (wcnt_reg < N_WR) begin
                        ready_reg <= 1'b1;
                        state_reg <= FETCH;
                    end else begin
                        settle_reg <= '0;
                        state_reg  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        bus_reg   <= 1'b1;
                        we_reg    <= 1'b0;
                        state_reg <= RD_REQ;
                    end else begin
                        settle_reg <= settle_reg + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (wbm_ack_i) begin
                        // The final result word only has 16 significant bits.
                        res_data_reg  <= (rcnt_reg == LAST_RD) ? {16'h0000, wbm_dat_i[15:0]} : wbm_dat_i;
                        res_valid_reg <= 1'b1;
                        rcnt_reg      <= rcnt_reg + 1'b1;
                        bus_reg       <= 1'b0;
                        state_reg     <= RD_GAP;
                    end else if (ack_timeout) begin
                        bus_reg   <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= ERR;
                    end
                end
                RD_GAP: begin
                    if (rcnt_reg < N_RD) begin
                        bus_reg   <= 1'b1;
                        we_reg    <= 1'b0;
                        state_reg <= RD_REQ;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                ERR: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign src_ready_o = ready_reg;
    assign res_valid_o = res_valid_reg;
    assign res_data_o  = res_data_reg;
    assign busy_o      = busy_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign wbm_cyc_o   = bus_reg;
    assign wbm_stb_o   = bus_reg;
    assign wbm_we_o    = we_reg;
    assign wbm_sel_o   = bus_reg ? 4'hF : 4'h0;
    assign wbm_adr_o   = bus_reg ? BASE_ADDRESS : 32'h0;
    assign wbm_dat_o   = dat_reg;

endmodule
